dff_bank_arbiter: RTL and testbench
===================================

Name: dff_bank_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one bank of D flip-flop registers between NREQ requesters.
- Each requester issues a single read or write through a req/gnt/done handshake. The arbiter captures the winner's command, performs the bank access, and returns read data.
- Sits between requester logic and the storage flops. It is the only path by which any requester reaches the flops.

Parameters:
- NREQ, 4, number of requesters (≥2).
- DW, 8, register data width.
- NREG, 4, number of registers in the bank (≥2).
- AW, $clog2(NREG), address width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- we  in  NREQ  per-requester op: 1 = write, 0 = read.
- addr  in  NREQ*AW  per-requester address; slice i = [i*AW +: AW].
- wdata  in  NREQ*DW  per-requester write data; slice i = [i*DW +: DW].
- gnt  out  NREQ  one-hot grant; high during ACCESS and DONE.
- done  out  NREQ  one-hot, one-cycle completion pulse.
- rdata  out  DW  read data of the last completed read.
- rvalid  out  1  high in the DONE cycle of a read.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, gnt=0, done=0, rdata=0, rvalid=0, rr pointer ptr=0, all bank registers=0. All are cleared immediately on rst assertion.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: if |req at edge E0, pick winner w = first set req bit searching ptr, ptr+1, ... mod NREQ. At E0: capture we[w], addr slice w, wdata slice w; gnt<=onehot(w); ptr<=(w+1) mod NREQ; state->ACCESS. If no req, stay in IDLE.
  - ACCESS (1 cycle): at edge E1, perform the op.
    - Write: bank[addr_q]<=wdata_q.
    - Read: rdata<=bank[addr_q] (value as of E1, before any same-edge write; none can occur).
    - Then done<=onehot(w), rvalid<=~we_q, state->DONE.
  - DONE (1 cycle): gnt and done both high. At E2: gnt<=0, done<=0, rvalid<=0, state->IDLE.
- Latency: req sampled at E0, done visible in the cycle after E1. Fixed 3 cycles per transaction; throughput is 1 op per 3 cycles.
- Requester rules:
  - Hold req, we, addr, wdata stable until sampled at E0; they are don't-care afterwards.
  - Deassert req no later than edge E2. A req still high in IDLE is a new request.
- Read data: rdata holds its value until the next completed read; writes do not alter it.
- Simultaneous requests: exactly one grant; the others wait. Starvation-free: any held req is granted within NREQ transactions.
- Out-of-range address (addr ≥ NREG when NREG is not a power of 2): write ignored; read returns 0; handshake completes normally.
- Reset mid-operation: returns to IDLE. A pending write is not performed unless E1 already occurred. No done pulse is issued.
- Bank: the flops are written only in ACCESS. No requester sees the bank directly.

Optional Feature:
- Macro: DFF_BANK_ARB_QBAR_EN.
- Defined: adds port rdata_n (out, DW) = ~rdata at all times. Its reset value is all ones.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package dff_arb_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, ACCESS, DONE};
  - default-width localparams DEF_NREQ=4, DEF_DW=8, DEF_NREG=4.
- One sub-module, dff_reg_bank: NREG×DW async-reset flop array with ports clk, rst, we, waddr, wdata, raddr, rdata_comb. The arbiter registers rdata itself.

Test Plan:
- Reset: assert rst mid-run → gnt=0000, done=0000, rdata=8'h00, rvalid=0, immediately and without waiting for a clock edge.
- Write then read: req[1]=1, we=1, addr=2, wdata=8'hA5 → gnt=0010 one cycle later, done=0010 two cycles later. Then read addr 2 from req[3] → done=1000, rvalid=1, rdata=8'hA5 in the same cycle.
- Round-robin: req=1111 held, re-presented after every done → grant order 0,1,2,3,0, with gnt changes every 3 cycles.
- Pointer start: after a grant to requester 1 (ptr=2), req=0101 → first grant 0100, then 0001.
- Reset mid-ACCESS during a write of 8'h3C to addr 1 → no done pulse; subsequent read of addr 1 returns 8'h00.
- With DFF_BANK_ARB_QBAR_EN defined: read of 8'hA5 → rdata_n=8'h5A; after reset rdata_n=8'hFF.

Source files
------------

// File: rtl/dff_arb_pkg.sv
// Shared types and default sizes for the DFF bank arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dff_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DEF_NREQ = 4;
  localparam int DEF_DW   = 8;
  localparam int DEF_NREG = 4;

endpackage

// File: rtl/dff_reg_bank.sv
// NREG x DW register bank with one write port and one combinational read port.
// Latency: write lands at the clock edge; read is combinational from the flops.
// Backpressure: none; out-of-range writes are dropped, out-of-range reads return 0.
//
// Ports: clk, rst (async active-high), we/waddr/wdata write port,
//        raddr/rdata_comb read port.
module dff_reg_bank
  import dff_arb_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int NREG = DEF_NREG,
  parameter int AW   = $clog2(DEF_NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata_comb
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (int'(waddr) < NREG)) begin
      mem[waddr] <= wdata;
    end
  end

  // Addresses beyond the populated registers only exist when NREG is not a power of 2.
  assign rdata_comb = (int'(raddr) < NREG) ? mem[raddr] : '0;

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sharing one DFF register bank between NREQ requesters.
// Latency: fixed 3 cycles per op (grant, access, done); 1 op per 3 cycles.
// Backpressure: losers keep req high and wait; each held req is served within NREQ ops.
//
// Ports: clk, rst (async active-high); per-requester req/we/addr/wdata (packed slices);
//        gnt/done one-hot, rdata/rvalid for reads.
// Optional: define DFF_BANK_ARB_QBAR_EN to add rdata_n (= ~rdata, resets to all ones).
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  parameter  int DW   = DEF_DW,
  parameter  int NREG = DEF_NREG,
  localparam int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [DW-1:0]     rdata,
`ifdef DFF_BANK_ARB_QBAR_EN
  output logic [DW-1:0]     rdata_n,
`endif
  output logic              rvalid
);

  localparam int PW = $clog2(NREQ);

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] cand;
  logic          win_vld;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] bank_rdata;
  logic          bank_we;

  // Winner = first set req bit scanning upward from ptr, wrapping at NREQ.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'((int'(ptr) + i) % NREQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      done    <= '0;
      rdata   <= '0;
      rvalid  <= 1'b0;
      ptr     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            we_q    <= we[win_idx];
            addr_q  <= addr[win_idx*AW +: AW];
            wdata_q <= wdata[win_idx*DW +: DW];
            gnt     <= NREQ'(1) << win_idx;
            ptr     <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          // The bank write for this op happens on the same edge via bank_we.
          if (!we_q) begin
            rdata <= bank_rdata;
          end
          done   <= gnt;
          rvalid <= ~we_q;
          state  <= DONE;
        end
        DONE: begin
          gnt    <= '0;
          done   <= '0;
          rvalid <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bank_we = (state == ACCESS) && we_q;

  dff_reg_bank #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .we         (bank_we),
    .waddr      (addr_q),
    .wdata      (wdata_q),
    .raddr      (addr_q),
    .rdata_comb (bank_rdata)
  );

`ifdef DFF_BANK_ARB_QBAR_EN
  assign rdata_n = ~rdata;
`endif

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter with a scoreboard of expected completions.
// Latency: n/a.
// Backpressure: n/a.
module tb_dff_bank_arbiter;
  import dff_arb_pkg::*;

  localparam int NREQ = DEF_NREQ;
  localparam int DW   = DEF_DW;
  localparam int NREG = DEF_NREG;
  localparam int AW   = $clog2(NREG);

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rdata;
  logic               rvalid;
`ifdef DFF_BANK_ARB_QBAR_EN
  logic [DW-1:0]      rdata_n;
`endif

  dff_bank_arbiter #(
    .NREQ (NREQ),
    .DW   (DW),
    .NREG (NREG)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .gnt    (gnt),
    .done   (done),
    .rdata  (rdata),
`ifdef DFF_BANK_ARB_QBAR_EN
    .rdata_n(rdata_n),
`endif
    .rvalid (rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic          w;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            mptr     = 0;
  logic [DW-1:0] mbank [NREG];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[i]          = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic model_reset();
    mptr = 0;
    for (int i = 0; i < NREG; i++) mbank[i] = '0;
  endtask

  task automatic check_rd(input string tag, input logic [DW-1:0] exp_d);
    logic [DW-1:0] inv;
    check(tag, rdata, exp_d);
`ifdef DFF_BANK_ARB_QBAR_EN
    inv = ~exp_d;
    check({tag, "_n"}, rdata_n, inv);
`else
    inv = '0;
`endif
  endtask

  // Predict grant order and results for all requesters in mask, then drive and score.
  task automatic run_txns(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] pend;
    exp_t            e;
    int              p;
    int              cyc;
    int              last_done;
    logic [AW-1:0]   a;
    pend = mask;
    p    = mptr;
    while (pend != '0) begin
      while (!pend[p]) p = (p + 1) % NREQ;
      a     = addr[p*AW +: AW];
      e.idx = p;
      e.w   = we[p];
      if (we[p]) begin
        mbank[a] = wdata[p*DW +: DW];
        e.d      = '0;
      end else begin
        e.d = mbank[a];
      end
      sb.push_back(e);
      pend[p] = 1'b0;
      p       = (p + 1) % NREQ;
    end
    mptr = p;

    @(negedge clk);
    check("idle_done", done, 0);
    req       = mask;
    cyc       = 0;
    last_done = -1;
    while (sb.size() > 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("gnt_first", gnt, 32'd1 << sb[0].idx);
      if (done != '0) begin
        e = sb.pop_front();
        check("done", done, 32'd1 << e.idx);
        check("gnt_in_done", gnt, 32'd1 << e.idx);
        check("rvalid", rvalid, !e.w);
        if (!e.w) check_rd("rdata", e.d);
        if (last_done < 0) check("latency", cyc, 2);
        else check("spacing", cyc - last_done, 3);
        last_done  = cyc;
        req[e.idx] = 1'b0;
      end
    end
    if (sb.size() > 0) begin
      check("timeout_pending", sb.size(), 0);
      sb.delete();
    end
    req = '0;
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    model_reset();
    #1;
    check("reset_gnt", gnt, 0);
    check("reset_done", done, 0);
    check("reset_rvalid", rvalid, 0);
    check_rd("reset_rdata", 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Write A5 to addr 2 from requester 1, read it back from requester 3.
    set_cmd(1, 1'b1, 2'd2, 8'hA5);
    run_txns(4'b0010);
    set_cmd(3, 1'b0, 2'd2, 8'h00);
    run_txns(4'b1000);

    // All four requesting: order 0,1,2,3 then 0 again.
    set_cmd(0, 1'b1, 2'd0, 8'h11);
    set_cmd(1, 1'b0, 2'd0, 8'h00);
    set_cmd(2, 1'b1, 2'd3, 8'hC3);
    set_cmd(3, 1'b0, 2'd3, 8'h00);
    run_txns(4'b1111);
    set_cmd(0, 1'b0, 2'd2, 8'h00);
    run_txns(4'b0001);

    // Grant to requester 1 moves ptr to 2; 0101 must serve 2 before 0.
    set_cmd(1, 1'b0, 2'd3, 8'h00);
    run_txns(4'b0010);
    set_cmd(0, 1'b0, 2'd0, 8'h00);
    set_cmd(2, 1'b1, 2'd1, 8'h7E);
    run_txns(4'b0101);

    // Random masks and commands.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NREQ; i++)
        set_cmd(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG - 1)),
                DW'($urandom_range(0, 255)));
      run_txns(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
    end

    // Leave A5 in rdata so the reset clearing it is visible.
    set_cmd(2, 1'b1, 2'd0, 8'hA5);
    run_txns(4'b0100);
    set_cmd(1, 1'b0, 2'd0, 8'h00);
    run_txns(4'b0010);

    // Reset while a write of 3C to addr 1 sits in ACCESS.
    set_cmd(0, 1'b1, 2'd1, 8'h3C);
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    check("gnt_pre_rst", gnt, 32'd1);
    req = '0;
    #2 rst = 1'b1;
    #1;
    check("midrst_gnt", gnt, 0);
    check("midrst_done", done, 0);
    check("midrst_rvalid", rvalid, 0);
    check_rd("midrst_rdata", 8'h00);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_no_done", done, 0);
    end
    set_cmd(2, 1'b0, 2'd1, 8'h00);
    run_txns(4'b0100);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
